// File: rtl/sseg_pkg.sv
// Shared types, segment patterns and helpers for the multiplexed
// seven-segment display and its binary-to-BCD converter.
package sseg_pkg;

    // Conversion FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } b2b_state_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Widest BCD result: a 32-bit value needs 10 decimal digits
    localparam int MAX_BCD_DIGITS = 10;

    // ceil(width * log10(2)) in integer arithmetic
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

    // Digit decoder; nibbles above 9 cannot come out of the converter
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Overflow without forming 10^num_digits: any nonzero nibble at or
    // above position num_digits means the value has too many digits.
    function automatic logic upper_nonzero(input logic [MAX_BCD_DIGITS*4-1:0] bcd,
                                           input int num_digits);
        logic any_nz;
        any_nz = 1'b0;
        for (int i = 0; i < MAX_BCD_DIGITS; i++) begin
            if (i >= num_digits && bcd[i*4 +: 4] != 4'd0) begin
                any_nz = 1'b1;
            end
        end
        return any_nz;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, CNT_WIDTH shifts,
// then a one-cycle COMMIT in which done pulses and bcd holds the result.
// Handshake: start is a single-cycle request honoured only while busy is low;
// requests while busy is high are dropped. done is high for exactly one
// cycle and bcd is valid during that cycle.
module bin2bcd_seq
    import sseg_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int BCD_DIGITS = bcd_digits(CNT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    value,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_DIGITS*4-1:0] bcd,
    output b2b_state_t              state
);

    localparam int CNT_W = $clog2(CNT_WIDTH);
    localparam int BCD_W = BCD_DIGITS * 4;

    b2b_state_t             state_q, state_d;
    logic [CNT_WIDTH-1:0]   shreg;
    logic [BCD_W-1:0]       work;
    logic [BCD_W-1:0]       adj;
    logic [CNT_W-1:0]       cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: SHIFT lasts exactly CNT_WIDTH cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt == CNT_W'(CNT_WIDTH - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add 3 to every nibble that is 5 or more before the next shift
    always_comb begin
        adj = work;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (work[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
        end
    end

    // Datapath: capture on start, then shift the captured value into the BCD register
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            work  <= '0;
            cnt   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg <= value;
                        work  <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    work  <= (adj << 1) | BCD_W'(shreg[CNT_WIDTH-1]);
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == COMMIT);
    assign bcd   = work;
    assign state = state_q;

endmodule

// File: rtl/sseg_mux_display.sv
// Multiplexed common-anode seven-segment display driven from a binary counter.
// A conversion result is committed atomically, then scanned one digit per
// REFRESH_DIV clocks. Optional macro SSEG_LEADING_ZERO_BLANK_EN blanks digits
// above the most significant nonzero digit (digit 0 always shown).
module sseg_mux_display
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int CNT_WIDTH   = 32,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  counter,
    input  logic                  update,
    output logic                  busy,
    output logic                  ovf,
    output logic [6:0]            sseg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int BCD_DIGITS = bcd_digits(CNT_WIDTH);
    localparam int DIV_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                          conv_busy, conv_done, conv_start;
    logic [BCD_DIGITS*4-1:0]       conv_bcd;
    b2b_state_t                    conv_state;
    logic [MAX_BCD_DIGITS*4-1:0]   bcd_ext;
    logic [NUM_DIGITS*4-1:0]       committed;
    logic                          ovf_q;
    logic [DIV_W-1:0]              div_q;
    logic [IDX_W-1:0]              idx_q;
    logic [3:0]                    cur_nib;
    logic                          blank;
    logic [6:0]                    seg_d;
    logic [NUM_DIGITS-1:0]         an_d;

    // Requests are only meaningful while the converter is idle
    assign conv_start = update & (conv_state == IDLE);

    bin2bcd_seq #(
        .CNT_WIDTH  (CNT_WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .value (counter),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .state (conv_state)
    );

    assign busy = conv_busy;
    assign ovf  = ovf_q;

    // Zero-extend the converter result to the widest supported BCD width
    always_comb begin
        bcd_ext = '0;
        bcd_ext[BCD_DIGITS*4-1:0] = conv_bcd;
    end

    // Commit the finished conversion in one step so the display never shows a partial value
    always_ff @(posedge clk) begin
        if (rst) begin
            committed <= '0;
            ovf_q     <= 1'b0;
        end else if (conv_done) begin
            committed <= bcd_ext[NUM_DIGITS*4-1:0];
            ovf_q     <= upper_nonzero(bcd_ext, NUM_DIGITS);
        end
    end

    // Refresh divider and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Select the current nibble, apply blanking and overflow dashes, build the anode mask
    always_comb begin
        cur_nib = '0;
        an_d    = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = committed[i*4 +: 4];
                an_d[i] = 1'b0;
            end
        end
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        begin
            logic higher_nz;
            higher_nz = 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i >= int'(idx_q) && committed[i*4 +: 4] != 4'd0) higher_nz = 1'b1;
            end
            blank = (idx_q != '0) && !higher_nz;
        end
`else
        blank = 1'b0;
`endif
        if (ovf_q)      seg_d = SEG_DASH;
        else if (blank) seg_d = SEG_BLANK;
        else            seg_d = seg_decode(cur_nib);
    end

    // Anode and segment registers update together so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            sseg <= SEG_BLANK;
            an   <= '1;
        end else begin
            sseg <= seg_d;
            an   <= an_d;
        end
    end

endmodule

// File: tb/tb_sseg_mux_display.sv
// Bench for sseg_mux_display with NUM_DIGITS=4, CNT_WIDTH=16, REFRESH_DIV=4.
// Drivers push the expected display image when they issue a conversion;
// the monitor pops it when busy falls and checks a full scan cycle.
`timescale 1ns/1ps
module tb_sseg_mux_display;

    localparam int EW = 29;  // {ovf, digit3, digit2, digit1, digit0}

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PD = 7'b0111111;
    localparam logic [6:0] PB = 7'b1111111;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = PB;
`else
    localparam logic [6:0] LZ = P0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        update;
    logic [15:0] counter;
    logic        busy;
    logic        ovf;
    logic [6:0]  sseg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    sseg_mux_display #(
        .NUM_DIGITS  (4),
        .CNT_WIDTH   (16),
        .REFRESH_DIV (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .counter (counter),
        .update  (update),
        .busy    (busy),
        .ovf     (ovf),
        .sseg    (sseg),
        .an      (an)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic o, input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {o, d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample 16 consecutive cycles starting at the current negedge
    task automatic check_display(input logic [EW-1:0] exp, input string tag);
        int seen[4];
        int idx;
        for (int d = 0; d < 4; d++) seen[d] = 0;
        for (int c = 0; c < 16; c++) begin
            case (an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            n_checks++;
            if (idx < 0) begin
                n_fail++;
                $display("FAIL %s an_onehot: got %b expected one low bit", tag, an);
            end else begin
                seen[idx]++;
                chk($sformatf("%s seg_digit%0d", tag, idx), 32'(sseg), 32'(exp[idx*7 +: 7]));
                chk($sformatf("%s ovf", tag), 32'(ovf), 32'(exp[28]));
            end
            @(negedge clk);
        end
        for (int d = 0; d < 4; d++) chk($sformatf("%s dwell_digit%0d", tag, d), seen[d], 4);
    endtask

    task automatic wait_busy_fall(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s busy_timeout: got %b expected 0", tag, busy);
        end
    endtask

    task automatic convert(input logic [15:0] value, input logic [EW-1:0] exp, input string tag);
        exp_q.push_back(exp);
        counter = value;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
        wait_busy_fall(tag);
        repeat (22) @(negedge clk);
    endtask

    // Monitor: measure busy length, pop expected image at each completed conversion
    initial begin : monitor
        int run;
        logic [EW-1:0] e;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                run = 0;
            end else if (busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                chk("busy_length", run, 17);
                run = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_conversion: got busy pulse expected none");
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check_display(e, "conv");
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    // Reset and driver sequence
    initial begin : driver
        int hits;
        rst     = 1'b1;
        update  = 1'b0;
        counter = '0;

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_sseg", 32'(sseg), 32'(PB));
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_ovf", 32'(ovf), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_an", 32'(an), 32'b1110);
        chk("first_sseg", 32'(sseg), 32'(P0));
        check_display(mk(1'b0, LZ, LZ, LZ, P0), "idle_zero");

        convert(16'd1234,  mk(1'b0, P1, P2, P3, P4), "c1234");
        convert(16'd10000, mk(1'b1, PD, PD, PD, PD), "c10000");
        convert(16'd65535, mk(1'b1, PD, PD, PD, PD), "c65535");
        convert(16'd9999,  mk(1'b0, P9, P9, P9, P9), "c9999");

        // Second request while busy must be dropped
        exp_q.push_back(mk(1'b0, LZ, LZ, P4, P2));
        counter = 16'd42;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        counter = 16'd77;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
        wait_busy_fall("c42");
        repeat (22) @(negedge clk);

        convert(16'd7,    mk(1'b0, LZ, LZ, LZ, P7), "c7");
        convert(16'd0,    mk(1'b0, LZ, LZ, LZ, P0), "c0");
        convert(16'd9080, mk(1'b0, P9, P0, P8, P0), "c9080");

        // Request during the COMMIT cycle must be dropped
        exp_q.push_back(mk(1'b0, LZ, P1, P2, P3));
        counter = 16'd123;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
        repeat (16) @(negedge clk);
        counter = 16'd999;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
        wait_busy_fall("c123");
        repeat (22) @(negedge clk);

        // Reset in the middle of a conversion
        counter = 16'd5555;
        update  = 1'b1;
        @(negedge clk);
        update  = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ovf", 32'(ovf), 0);
        chk("midrst_sseg", 32'(sseg), 32'(PB));
        chk("midrst_an", 32'(an), 32'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_first_an", 32'(an), 32'b1110);
        chk("midrst_first_sseg", 32'(sseg), 32'(P0));
        check_display(mk(1'b0, LZ, LZ, LZ, P0), "midrst_zero");
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            if (sseg === P5 || busy !== 1'b0) hits++;
            @(negedge clk);
        end
        chk("midrst_no_5555", hits, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
